ex_mem_reg: RTL and testbench

//  EX/MEM pipeline register of the 64-bit RV64 core. Captures ALU Result, Zero and GreaterThanEqualZero

---
 rtl/ex_mem_reg.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU results and control, resolves conditional branches,
// drives a one-cycle fetch redirect, squashes the wrong-path slot and counts branches.
module ex_mem_reg #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic              ex_gte_zero,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_branch,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_reg_write,
  output logic [DATA_W-1:0] mem_branch_target,
  output logic              redirect,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] taken_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic              m2r_q, m2r_d;
  logic              rwr_q, rwr_d;
  logic              taken_q, taken_d;
  logic [PERF_W-1:0] bcnt_q, bcnt_d;
  logic [PERF_W-1:0] tcnt_q, tcnt_d;

  logic taken;
  logic redirect_w;
  logic bubble;
  logic load_en;

  // The ALU computes a-b, so the flags stand in for the comparison; signed overflow is ignored.
  always_comb begin
    taken = 1'b0;
    if (ex_branch) begin
      case (ex_funct3)
        3'b000:  taken = ex_zero;
        3'b001:  taken = !ex_zero;
        3'b100:  taken = !ex_gte_zero;
        3'b101:  taken = ex_gte_zero;
        default: taken = 1'b0;
      endcase
    end
  end

  assign redirect_w = valid_q & taken_q;
  assign bubble     = flush | (!stall & redirect_w);
  assign load_en    = !flush & !stall & !redirect_w;

  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    wdat_d  = wdat_q;
    tgt_d   = tgt_q;
    rd_d    = rd_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    m2r_d   = m2r_q;
    rwr_d   = rwr_q;
    taken_d = taken_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    if (bubble) begin
      valid_d = 1'b0;
      alu_d   = '0;
      wdat_d  = '0;
      tgt_d   = '0;
      rd_d    = '0;
      mrd_d   = 1'b0;
      mwr_d   = 1'b0;
      m2r_d   = 1'b0;
      rwr_d   = 1'b0;
      taken_d = 1'b0;
    end else if (load_en) begin
      // Control bits are qualified by valid so an empty slot never writes state downstream.
      valid_d = ex_valid;
      alu_d   = ex_alu_result;
      wdat_d  = ex_write_data;
      tgt_d   = ex_branch_target;
      rd_d    = ex_rd;
      mrd_d   = ex_mem_read   & ex_valid;
      mwr_d   = ex_mem_write  & ex_valid;
      m2r_d   = ex_mem_to_reg & ex_valid;
      rwr_d   = ex_reg_write  & ex_valid;
      taken_d = taken         & ex_valid;
      if (ex_valid && ex_branch) begin
        bcnt_d = bcnt_q + 1'b1;
        tcnt_d = tcnt_q + {{(PERF_W-1){1'b0}}, taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      wdat_q  <= '0;
      tgt_q   <= '0;
      rd_q    <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      m2r_q   <= 1'b0;
      rwr_q   <= 1'b0;
      taken_q <= 1'b0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      wdat_q  <= wdat_d;
      tgt_q   <= tgt_d;
      rd_q    <= rd_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      m2r_q   <= m2r_d;
      rwr_q   <= rwr_d;
      taken_q <= taken_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign mem_valid         = valid_q;
  assign mem_alu_result    = alu_q;
  assign mem_write_data    = wdat_q;
  assign mem_rd            = rd_q;
  assign mem_mem_read      = mrd_q;
  assign mem_mem_write     = mwr_q;
  assign mem_mem_to_reg    = m2r_q;
  assign mem_reg_write     = rwr_q;
  assign mem_branch_target = tgt_q;
  assign redirect          = redirect_w;
  assign branch_count      = bcnt_q;
  assign taken_count       = tcnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios then random traffic against a reference model.
// Counters are built 8 bits wide here so the wrap case is reachable in a few hundred cycles.
module tb_ex_mem_reg;
  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int PERF_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic              ex_valid = 1'b0, ex_zero = 1'b1, ex_gte_zero = 1'b1;
  logic [DATA_W-1:0] ex_alu_result = '0, ex_write_data = '0, ex_branch_target = '0;
  logic [2:0]        ex_funct3 = '0;
  logic              ex_branch = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic              ex_mem_to_reg = 1'b0, ex_reg_write = 1'b0;
  logic [RD_W-1:0]   ex_rd = '0;
  logic              mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, redirect;
  logic [DATA_W-1:0] mem_alu_result, mem_write_data, mem_branch_target;
  logic [RD_W-1:0]   mem_rd;
  logic [PERF_W-1:0] branch_count, taken_count;

  ex_mem_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_gte_zero(ex_gte_zero),
    .ex_write_data(ex_write_data), .ex_branch_target(ex_branch_target), .ex_funct3(ex_funct3),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_branch_target(mem_branch_target), .redirect(redirect),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid, mr, mw, m2r, rw, tk;
    logic [DATA_W-1:0] alu, wd, tgt;
    logic [RD_W-1:0]   rd;
    int unsigned       bc, tc;
  } model_t;

  model_t m;
  int vectors = 0;
  int miscompares = 0;

  // Branch outcome from the signed value of the difference a-b (the ALU result).
  function automatic logic branch_taken(input logic [2:0] f3, input logic [DATA_W-1:0] diff);
    longint sd;
    sd = longint'(diff);
    case (f3)
      3'd0: return sd == 0;
      3'd1: return sd != 0;
      3'd4: return sd < 0;
      3'd5: return sd >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic model_t empty_slot(input model_t s);
    model_t r;
    r = s;
    r.valid = 0; r.mr = 0; r.mw = 0; r.m2r = 0; r.rw = 0; r.tk = 0;
    r.alu = '0; r.wd = '0; r.tgt = '0; r.rd = '0;
    return r;
  endfunction

  task automatic model_edge();
    logic tk;
    if (reset) begin
      m = empty_slot(m); m.bc = 0; m.tc = 0;
    end else if (flush) begin
      m = empty_slot(m);
    end else if (stall) begin
      // hold
    end else if (m.valid && m.tk) begin
      m = empty_slot(m);
    end else begin
      tk = ex_branch && branch_taken(ex_funct3, ex_alu_result);
      m.valid = ex_valid;
      m.alu = ex_alu_result; m.wd = ex_write_data; m.tgt = ex_branch_target; m.rd = ex_rd;
      m.mr = ex_valid & ex_mem_read;  m.mw = ex_valid & ex_mem_write;
      m.m2r = ex_valid & ex_mem_to_reg; m.rw = ex_valid & ex_reg_write;
      m.tk = ex_valid & tk;
      if (ex_valid && ex_branch) begin
        m.bc = (m.bc + 1) % (1 << PERF_W);
        m.tc = (m.tc + (tk ? 1 : 0)) % (1 << PERF_W);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("mem_valid", 64'(mem_valid), 64'(m.valid));
    chk("mem_alu_result", mem_alu_result, m.alu);
    chk("mem_write_data", mem_write_data, m.wd);
    chk("mem_branch_target", mem_branch_target, m.tgt);
    chk("mem_rd", 64'(mem_rd), 64'(m.rd));
    chk("mem_mem_read", 64'(mem_mem_read), 64'(m.mr));
    chk("mem_mem_write", 64'(mem_mem_write), 64'(m.mw));
    chk("mem_mem_to_reg", 64'(mem_mem_to_reg), 64'(m.m2r));
    chk("mem_reg_write", 64'(mem_reg_write), 64'(m.rw));
    chk("redirect", 64'(redirect), 64'(m.valid & m.tk));
    chk("branch_count", 64'(branch_count), 64'(m.bc));
    chk("taken_count", 64'(taken_count), 64'(m.tc));
    chk("bubble_rule", 64'((mem_reg_write | mem_mem_write) & ~mem_valid), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] tgt, input logic [2:0] f3, input logic br,
                       input logic mr, input logic mw, input logic rw, input logic [RD_W-1:0] rd);
    ex_valid = v; ex_alu_result = res; ex_zero = (res == '0); ex_gte_zero = !res[DATA_W-1];
    ex_write_data = wd; ex_branch_target = tgt; ex_funct3 = f3; ex_branch = br;
    ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = mr; ex_reg_write = rw; ex_rd = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m = empty_slot(m); m.bc = 0; m.tc = 0;
    // 1. reset and a plain ALU op
    reset = 1; idle();
    tick(); tick();
    chk("reset_valid", 64'(mem_valid), 64'd0);
    reset = 0;
    drive(1, 64'h10, 64'h0, 64'h0, 3'd0, 0, 0, 0, 1, 5'd5);
    tick();
    chk("add_result", mem_alu_result, 64'h10);
    chk("add_rd", 64'(mem_rd), 64'd5);
    chk("add_no_redirect", 64'(redirect), 64'd0);
    // 2. taken beq, wrong-path instruction squashed
    drive(1, 64'h0, 64'h0, 64'h200, 3'd0, 1, 0, 0, 0, 5'd0);
    tick();
    chk("beq_redirect", 64'(redirect), 64'd1);
    chk("beq_target", mem_branch_target, 64'h200);
    chk("beq_bcnt", 64'(branch_count), 64'd1);
    chk("beq_tcnt", 64'(taken_count), 64'd1);
    drive(1, 64'h44, 64'h0, 64'h0, 3'd0, 0, 0, 0, 1, 5'd7);
    tick();
    chk("squash_valid", 64'(mem_valid), 64'd0);
    chk("squash_redirect", 64'(redirect), 64'd0);
    // 3. blt/bge with a positive difference
    reset = 1; idle(); tick(); reset = 0;
    drive(1, 64'h5, 64'h0, 64'h300, 3'd4, 1, 0, 0, 0, 5'd0);
    tick();
    chk("blt_not_taken", 64'(redirect), 64'd0);
    chk("blt_bcnt", 64'(branch_count), 64'd1);
    chk("blt_tcnt", 64'(taken_count), 64'd0);
    drive(1, 64'h5, 64'h0, 64'h340, 3'd5, 1, 0, 0, 0, 5'd0);
    tick();
    chk("bge_taken", 64'(redirect), 64'd1);
    idle(); tick();
    // 4. taken bne held by stall
    drive(1, 64'h7, 64'h0, 64'h480, 3'd1, 1, 0, 0, 0, 5'd0);
    tick();
    chk("bne_redirect", 64'(redirect), 64'd1);
    stall = 1;
    drive(1, 64'h99, 64'h1, 64'h2, 3'd0, 1, 0, 1, 1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_redirect", 64'(redirect), 64'd1);
      chk("stall_target", mem_branch_target, 64'h480);
    end
    stall = 0;
    tick();
    chk("post_stall_redirect", 64'(redirect), 64'd0);
    // 5. flush beats stall with a store in EX
    flush = 1; stall = 1;
    drive(1, 64'h1000, 64'hdead, 64'h0, 3'd0, 0, 0, 1, 0, 5'd0);
    tick();
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_mwrite", 64'(mem_mem_write), 64'd0);
    flush = 0; stall = 0;
    // redirect and flush together
    drive(1, 64'h0, 64'h0, 64'h600, 3'd0, 1, 0, 0, 0, 5'd0);
    tick();
    flush = 1; tick(); flush = 0;
    chk("flush_clears_redirect", 64'(redirect), 64'd0);
    // 6. counter wrap
    reset = 1; idle(); tick(); reset = 0;
    drive(1, 64'h5, 64'h0, 64'h0, 3'd4, 1, 0, 0, 0, 5'd0);
    for (int i = 0; i < (1 << PERF_W) - 1; i++) tick();
    chk("bcnt_max", 64'(branch_count), 64'((1 << PERF_W) - 1));
    tick();
    chk("bcnt_wrap", 64'(branch_count), 64'd0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [DATA_W-1:0] res;
      case ($urandom_range(0, 3))
        0: res = '0;
        1: res = {1'b1, 31'($urandom), 32'($urandom)};
        default: res = {32'($urandom), 32'($urandom)};
      endcase
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3) != 0, res, {32'($urandom), 32'($urandom)},
            {32'($urandom), 32'($urandom)}, 3'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
